tdc_burst_avg: RTL

Measurement sequencer and result averager sitting directly downstream of the time-to-digital converter top. It issues `start` pulses to the TDC and captures each `count_out` when the TDC raises `ready`. Over a burst of 2^LOG2_N conversions it accumulates the samples and tracks min/max. It then presents mean/min/max to the readout logic with a valid/ack handshake.

---
 rtl/tdc_burst_avg.sv | 116 +++++++++++
 1 files changed

// File: rtl/tdc_burst_avg.sv
// tdc_burst_avg: sequences 2^LOG2_N TDC conversions and reports the burst
// mean/min/max behind a valid/ack handshake, aborting on a conversion timeout.
module tdc_burst_avg #(
  parameter int WIDTH     = 8,
  parameter int LOG2_N    = 3,
  parameter int START_LEN = 5,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             tdc_start,
  input  logic             tdc_ready,
  input  logic [WIDTH-1:0] tdc_count,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             timeout_err
);
  localparam int AW = WIDTH + LOG2_N;
  localparam int CW = $clog2((TIMEOUT > START_LEN ? TIMEOUT : START_LEN) + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LOG2_N-1:0] idx_q, idx_d;
  logic [AW-1:0]     acc_q, acc_d, acc_s;
  logic [WIDTH-1:0]  lo_q, lo_d, lo_s, hi_q, hi_d, hi_s;
  logic [WIDTH-1:0]  avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic              ready_q, terr_q, terr_d, rise;
  assign rise  = tdc_ready & ~ready_q;
  assign acc_s = acc_q + AW'(tdc_count);
  // the first sample of a burst seeds both running extremes; ties keep the old value
  assign lo_s  = (idx_q == '0 || tdc_count < lo_q) ? tdc_count : lo_q;
  assign hi_s  = (idx_q == '0 || tdc_count > hi_q) ? tdc_count : hi_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    avg_d   = avg_q;
    min_d   = min_q;
    max_d   = max_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = START;
        cnt_d   = '0;
        idx_d   = '0;
        acc_d   = '0;
        terr_d  = 1'b0;
      end
      START: if (cnt_q == CW'(START_LEN - 1)) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (rise) begin
        acc_d   = acc_s;
        lo_d    = lo_s;
        hi_d    = hi_s;
        idx_d   = idx_q + LOG2_N'(1);
        cnt_d   = '0;
        state_d = &idx_q ? DONE : START;
        avg_d   = &idx_q ? WIDTH'(acc_s >> LOG2_N) : avg_q;
        min_d   = &idx_q ? lo_s : min_q;
        max_d   = &idx_q ? hi_s : max_q;
      end else if (cnt_q == CW'(TIMEOUT)) begin
        state_d = DONE;
        terr_d  = 1'b1;
        avg_d   = '0;
        min_d   = '0;
        max_d   = '0;
      end
      DONE: state_d = ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      avg_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      terr_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      avg_q   <= avg_d;
      min_q   <= min_d;
      max_q   <= max_d;
      terr_q  <= terr_d;
      ready_q <= tdc_ready;
    end
  end
  assign tdc_start   = state_q == START;
  assign valid       = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign timeout_err = terr_q;
  assign avg_out     = avg_q;
  assign min_out     = min_q;
  assign max_out     = max_q;
endmodule
